// File: rtl/hazard_forward_unit.sv
// Hazard detection and operand forwarding for a five-stage pipeline.
// Tracks the EX, MEM and WB destination records, selects EX operand
// forwarding sources and raises load-use / jr stalls that freeze PC and
// IF/ID while injecting a bubble into EX.
module hazard_forward_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        id_valid,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rs,
    input  logic        id_uses_rt,
    input  logic [4:0]  id_dest,
    input  logic        id_reg_write,
    input  logic        id_mem_read,
    input  logic        id_branch_taken,
    input  logic        id_jump,
    input  logic        id_jr,
    output logic [1:0]  Ctrl_FwdA,
    output logic [1:0]  Ctrl_FwdB,
    output logic        Ctrl_Mux_Select_Stall,
    output logic        pc_write,
    output logic        ifid_write,
    output logic        ifid_flush,
    output logic [15:0] stall_count
);

    localparam logic [1:0] FWD_REG = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    logic [4:0]  r_ex_rs;
    logic [4:0]  r_ex_rt;
    logic [4:0]  r_ex_dest;
    logic        r_ex_reg_write;
    logic        r_ex_mem_read;
    logic [4:0]  r_mem_dest;
    logic        r_mem_reg_write;
    logic        r_mem_mem_read;
    logic [4:0]  r_wb_dest;
    logic        r_wb_reg_write;
    logic [15:0] r_stall_count;

    logic        w_load_use;
    logic        w_jr_stall;
    logic        w_stall;
    logic        w_redirect;
    logic [1:0]  w_fwd_a;
    logic [1:0]  w_fwd_b;

    // MEM result wins over WB because it is the younger write to the register.
    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic       mem_rw,
                                           input logic [4:0] mem_dest,
                                           input logic       wb_rw,
                                           input logic [4:0] wb_dest);
        logic [1:0] sel;
        sel = FWD_REG;
        if (mem_rw && (mem_dest != 5'd0) && (mem_dest == src)) begin
            sel = FWD_MEM;
        end else if (wb_rw && (wb_dest != 5'd0) && (wb_dest == src)) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

    // Operand forwarding selects, derived from the stage records only.
    always_comb begin
        w_fwd_a = fwd_sel(r_ex_rs, r_mem_reg_write, r_mem_dest, r_wb_reg_write, r_wb_dest);
        w_fwd_b = fwd_sel(r_ex_rt, r_mem_reg_write, r_mem_dest, r_wb_reg_write, r_wb_dest);
    end

    // Stall detection: load-use against EX, jr against EX writes or MEM loads.
    always_comb begin
        w_load_use = 1'b0;
        w_jr_stall = 1'b0;
        if (id_valid && r_ex_mem_read && (r_ex_dest != 5'd0)) begin
            if ((id_uses_rs && (id_rs == r_ex_dest)) ||
                (id_uses_rt && (id_rt == r_ex_dest))) begin
                w_load_use = 1'b1;
            end
        end
        if (id_valid && id_jr && (id_rs != 5'd0)) begin
            if ((r_ex_reg_write && (r_ex_dest == id_rs)) ||
                (r_mem_mem_read && (r_mem_dest == id_rs))) begin
                w_jr_stall = 1'b1;
            end
        end
        w_stall    = w_load_use | w_jr_stall;
        w_redirect = id_valid & (id_branch_taken | id_jump | id_jr);
    end

    // Pipeline records: EX takes the ID instruction or a bubble, older stages shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_rs         <= 5'd0;
            r_ex_rt         <= 5'd0;
            r_ex_dest       <= 5'd0;
            r_ex_reg_write  <= 1'b0;
            r_ex_mem_read   <= 1'b0;
            r_mem_dest      <= 5'd0;
            r_mem_reg_write <= 1'b0;
            r_mem_mem_read  <= 1'b0;
            r_wb_dest       <= 5'd0;
            r_wb_reg_write  <= 1'b0;
        end else begin
            r_wb_dest       <= r_mem_dest;
            r_wb_reg_write  <= r_mem_reg_write;
            r_mem_dest      <= r_ex_dest;
            r_mem_reg_write <= r_ex_reg_write;
            r_mem_mem_read  <= r_ex_mem_read;
            if (id_valid && !w_stall) begin
                r_ex_rs        <= id_uses_rs ? id_rs : 5'd0;
                r_ex_rt        <= id_uses_rt ? id_rt : 5'd0;
                r_ex_dest      <= id_dest;
                r_ex_reg_write <= id_reg_write;
                r_ex_mem_read  <= id_mem_read;
            end else begin
                r_ex_rs        <= 5'd0;
                r_ex_rt        <= 5'd0;
                r_ex_dest      <= 5'd0;
                r_ex_reg_write <= 1'b0;
                r_ex_mem_read  <= 1'b0;
            end
        end
    end

    // Saturating count of stalled cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= 16'd0;
        end else if (w_stall && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign Ctrl_FwdA             = w_fwd_a;
    assign Ctrl_FwdB             = w_fwd_b;
    assign Ctrl_Mux_Select_Stall = ~w_stall;
    assign pc_write              = ~w_stall;
    assign ifid_write            = ~w_stall;
    // A redirect seen during a stall is simply retried next cycle from held ID inputs.
    assign ifid_flush            = w_redirect & ~w_stall;
    assign stall_count           = r_stall_count;

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid;
    logic [4:0]  id_rs, id_rt, id_dest;
    logic        id_uses_rs, id_uses_rt, id_reg_write, id_mem_read;
    logic        id_branch_taken, id_jump, id_jr;
    logic [1:0]  Ctrl_FwdA, Ctrl_FwdB;
    logic        Ctrl_Mux_Select_Stall, pc_write, ifid_write, ifid_flush;
    logic [15:0] stall_count;

    hazard_forward_unit dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .id_dest(id_dest), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_branch_taken(id_branch_taken), .id_jump(id_jump), .id_jr(id_jr),
        .Ctrl_FwdA(Ctrl_FwdA), .Ctrl_FwdB(Ctrl_FwdB),
        .Ctrl_Mux_Select_Stall(Ctrl_Mux_Select_Stall), .pc_write(pc_write),
        .ifid_write(ifid_write), .ifid_flush(ifid_flush), .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Reference model: list of in-flight instructions, index = stages past ID
    // (0 = EX, 1 = MEM, 2 = WB). A producer k stages ahead forwards with code k.
    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] dest;
        logic       rw;
        logic       mr;
    } instr_t;

    instr_t pipe [3];
    int     m_cnt;
    logic   exp_stall;
    int     n_vec = 0;
    int     n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [1:0] m_fwd(input logic [4:0] src);
        for (int k = 1; k <= 2; k++) begin
            if (src != 5'd0 && pipe[k].rw && pipe[k].dest == src) return 2'(k);
        end
        return 2'd0;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++) pipe[k] = '0;
        m_cnt = 0;
    endtask

    // Settle, then compare every output with the model.
    task automatic eval();
        logic lu, jr, redir;
        #1;
        lu = id_valid && pipe[0].mr && pipe[0].dest != 5'd0 &&
             ((id_uses_rs && id_rs == pipe[0].dest) || (id_uses_rt && id_rt == pipe[0].dest));
        jr = id_valid && id_jr && id_rs != 5'd0 &&
             ((pipe[0].rw && pipe[0].dest == id_rs) || (pipe[1].mr && pipe[1].dest == id_rs));
        exp_stall = lu | jr;
        redir = id_valid && (id_branch_taken || id_jump || id_jr);
        chk("fwd_a", 32'(Ctrl_FwdA), 32'(m_fwd(pipe[0].rs)));
        chk("fwd_b", 32'(Ctrl_FwdB), 32'(m_fwd(pipe[0].rt)));
        chk("mux_sel", 32'(Ctrl_Mux_Select_Stall), 32'(!exp_stall));
        chk("pc_write", 32'(pc_write), 32'(!exp_stall));
        chk("ifid_write", 32'(ifid_write), 32'(!exp_stall));
        chk("ifid_flush", 32'(ifid_flush), 32'(redir && !exp_stall));
        chk("stall_count", 32'(stall_count), 32'(m_cnt));
    endtask

    // Clock edge: advance the model with the inputs the DUT just sampled.
    task automatic tick();
        instr_t nx;
        nx = '0;
        if (id_valid && !exp_stall) begin
            nx.rs   = id_uses_rs ? id_rs : 5'd0;
            nx.rt   = id_uses_rt ? id_rt : 5'd0;
            nx.dest = id_dest;
            nx.rw   = id_reg_write;
            nx.mr   = id_mem_read;
        end
        @(posedge clk);
        pipe[2] = pipe[1];
        pipe[1] = pipe[0];
        pipe[0] = nx;
        if (exp_stall && m_cnt < 65535) m_cnt++;
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic urs,
                         input logic [4:0] rt, input logic urt, input logic [4:0] dest,
                         input logic rw, input logic mr, input logic bt, input logic jp,
                         input logic jr);
        id_valid = v; id_rs = rs; id_uses_rs = urs; id_rt = rt; id_uses_rt = urt;
        id_dest = dest; id_reg_write = rw; id_mem_read = mr;
        id_branch_taken = bt; id_jump = jp; id_jr = jr;
    endtask

    task automatic nop();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic step();
        eval();
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_clear();
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        nop();
        model_clear();
        #12;
        rst_n = 1'b1;

        // Idle after reset
        eval();
        chk("rst_fwd_a", 32'(Ctrl_FwdA), 0);
        chk("rst_pc_write", 32'(pc_write), 1);
        chk("rst_flush", 32'(ifid_flush), 0);
        tick();

        // Forward from MEM
        drive(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0); step();
        drive(1, 8, 1, 0, 0, 3, 1, 0, 0, 0, 0); step();
        nop(); eval(); chk("fwd_mem", 32'(Ctrl_FwdA), 1); tick();
        nop(); step(); step();

        // Forward from WB with one unrelated instruction between
        drive(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0); step();
        drive(1, 1, 1, 2, 1, 5, 1, 0, 0, 0, 0); step();
        drive(1, 8, 1, 0, 0, 3, 1, 0, 0, 0, 0); step();
        nop(); eval(); chk("fwd_wb", 32'(Ctrl_FwdA), 2); tick();
        nop(); step(); step();

        // Both MEM and WB write reg 8: MEM wins
        drive(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0); step();
        drive(1, 0, 0, 0, 0, 8, 1, 0, 0, 0, 0); step();
        drive(1, 8, 1, 0, 0, 3, 1, 0, 0, 0, 0); step();
        nop(); eval(); chk("fwd_prio", 32'(Ctrl_FwdA), 1); tick();
        nop(); step(); step();

        // Register zero never forwards and never stalls
        drive(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0); step();
        drive(1, 0, 1, 0, 1, 4, 1, 0, 0, 0, 0);
        eval(); chk("r0_no_stall", 32'(pc_write), 1); tick();
        nop(); eval(); chk("r0_fwd_a", 32'(Ctrl_FwdA), 0); tick();
        nop(); step(); step();

        // Load-use: one stall cycle, then forward from WB
        drive(1, 0, 0, 0, 0, 9, 1, 1, 0, 0, 0); step();
        drive(1, 0, 0, 9, 1, 10, 1, 0, 0, 0, 0);
        eval();
        chk("lu_mux", 32'(Ctrl_Mux_Select_Stall), 0);
        chk("lu_pc", 32'(pc_write), 0);
        chk("lu_ifid", 32'(ifid_write), 0);
        tick();
        eval(); chk("lu_release", 32'(pc_write), 1); tick();
        nop(); eval();
        chk("lu_fwd_b", 32'(Ctrl_FwdB), 2);
        chk("lu_count", 32'(stall_count), 1);
        tick();
        nop(); step(); step();

        // jr after a load to r31: two stalls, flush on the third cycle
        do_reset();
        drive(1, 0, 0, 0, 0, 31, 1, 1, 0, 0, 0); step();
        drive(1, 31, 1, 0, 0, 0, 0, 0, 0, 0, 1);
        eval(); chk("jr_c1_pc", 32'(pc_write), 0); chk("jr_c1_flush", 32'(ifid_flush), 0); tick();
        eval(); chk("jr_c2_pc", 32'(pc_write), 0); chk("jr_c2_flush", 32'(ifid_flush), 0); tick();
        eval(); chk("jr_c3_flush", 32'(ifid_flush), 1); chk("jr_count", 32'(stall_count), 2); tick();
        nop(); step(); step();

        // Taken branch with no hazard
        drive(1, 1, 1, 2, 1, 0, 0, 0, 1, 0, 0);
        eval(); chk("br_flush", 32'(ifid_flush), 1); chk("br_pc", 32'(pc_write), 1); tick();
        nop(); eval(); chk("br_flush_end", 32'(ifid_flush), 0); tick();

        // Randomized traffic; ID inputs are held while the pipe is stalled
        for (int i = 0; i < 3000; i++) begin
            if (!exp_stall || i == 0) begin
                drive($urandom_range(0, 7) != 0,
                      5'($urandom_range(0, 3)), 1'($urandom),
                      5'($urandom_range(0, 3)), 1'($urandom),
                      ($urandom_range(0, 7) == 0) ? 5'd31 : 5'($urandom_range(0, 3)),
                      1'($urandom), $urandom_range(0, 2) == 0,
                      $urandom_range(0, 7) == 0, $urandom_range(0, 15) == 0,
                      $urandom_range(0, 5) == 0);
            end
            step();
            if (i % 700 == 699) do_reset();
        end

        // Saturation: pin the EX record to a load of r9 so the stall persists
        nop(); do_reset();
        drive(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        force dut.r_ex_mem_read = 1'b1;
        force dut.r_ex_dest = 5'd9;
        for (int i = 0; i < 65540; i++) @(posedge clk);
        #1;
        chk("sat_count", 32'(stall_count), 32'hFFFF);
        chk("sat_pc", 32'(pc_write), 0);
        release dut.r_ex_mem_read;
        release dut.r_ex_dest;
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_count", 32'(stall_count), 0);
        chk("rst_mid_pc", 32'(pc_write), 1);
        chk("rst_mid_ex_mr", 32'(dut.r_ex_mem_read), 0);
        chk("rst_mid_ex_dest", 32'(dut.r_ex_dest), 0);
        chk("rst_mid_mem_mr", 32'(dut.r_mem_mem_read), 0);
        chk("rst_mid_wb_rw", 32'(dut.r_wb_reg_write), 0);
        model_clear();
        rst_n = 1'b1;
        step();
        nop(); step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  asynchronous active-low reset.
REQ-004 id_valid  in  1  ID stage holds a real instruction.
REQ-005 id_rs, id_rt  in  5 each  ID source register numbers.
REQ-006 id_uses_rs, id_uses_rt  in  1 each  ID instruction reads rs / rt.
REQ-007 id_dest  in  5  ID destination register, already resolved to rt, rd or 31.
REQ-008 id_reg_write, id_mem_read  in  1 each  ID instruction writes a register / is a load.
REQ-009 id_branch_taken, id_jump, id_jr  in  1 each  ID redirect conditions; id_jr reads rs.
REQ-010 Ctrl_FwdA, Ctrl_FwdB  out  2 each  EX operand select: 0 = register, 1 = EX/MEM forward, 2 = MEM/WB forward; 3 is never driven.
REQ-011 Ctrl_Mux_Select_Stall  out  1  0 = inject zero control, 1 = pass control unit.
REQ-012 pc_write, ifid_write  out  1 each  PC and IF/ID register enables.
REQ-013 ifid_flush  out  1  clears IF/ID on the next edge.
REQ-014 stall_count  out  16  saturating count of stall cycles.

Function
REQ-015 Internal records SHALL be kept for each stage:
  - EX: rs, rt, dest, reg_write, mem_read
  - MEM: dest, reg_write, mem_read
  - WB: dest, reg_write
REQ-016 Records SHALL advance on every rising edge: WB<=MEM, MEM<=EX.
REQ-017 The EX record SHALL load from the ID inputs on a rising edge when stall=0 and id_valid=1.
REQ-018 When stall=1 or id_valid=0, the EX record SHALL receive a bubble: reg_write=0, mem_read=0, registers=0.
REQ-019 The EX record's rs/rt SHALL be stored as 0 when the matching id_uses_* is 0.
REQ-020 Ctrl_FwdA SHALL be combinational from records only:
  - 1 if MEM.reg_write, MEM.dest!=0 and MEM.dest==EX.rs;
  - else 2 if WB.reg_write, WB.dest!=0 and WB.dest==EX.rs;
  - else 0.
  - MEM has priority over WB.
REQ-021 Ctrl_FwdB SHALL follow the same rule with EX.rt.
REQ-022 A load-use stall SHALL be raised when all of the following hold: id_valid, EX.mem_read, EX.dest!=0, and EX.dest equals a used ID source (id_rs with id_uses_rs, or id_rt with id_uses_rt).
REQ-023 A jr stall SHALL be raised when all of the following hold: id_valid and id_jr, plus either EX.reg_write with EX.dest==id_rs!=0, or MEM.mem_read with MEM.dest==id_rs!=0.
REQ-024 stall SHALL equal (load-use stall OR jr stall), computed combinationally.
REQ-025 When stall=1, outputs SHALL be: Ctrl_Mux_Select_Stall=0, pc_write=0, ifid_write=0, ifid_flush=0.
REQ-026 When stall=0, outputs SHALL be: Ctrl_Mux_Select_Stall=1, pc_write=1, ifid_write=1.
REQ-027 ifid_flush SHALL equal id_valid AND (id_branch_taken OR id_jump OR id_jr) AND NOT stall.
REQ-028 A redirect coincident with a stall SHALL be deferred; it is re-evaluated on the following cycle from the held ID inputs.
REQ-029 stall_count SHALL increment by 1 on each rising edge where stall=1 and SHALL saturate at 16'hFFFF without wrapping.
REQ-030 The load-use stall SHALL last exactly 1 cycle, because the bubble clears EX.mem_read.
REQ-031 A jr stall SHALL last 1 or 2 cycles, depending on the hazard distance.

Reset
REQ-032 While rst_n=0, all records SHALL be cleared (all fields 0) and stall_count SHALL be 0, asynchronously.
REQ-033 After reset with id_valid=0, outputs SHALL be: Ctrl_FwdA=0, Ctrl_FwdB=0, Ctrl_Mux_Select_Stall=1, pc_write=1, ifid_write=1, ifid_flush=0.
REQ-034 A reset asserted mid-stall SHALL drop the stall immediately and discard all in-flight records.

Verification
REQ-035 The bench SHALL cover forwarding priority:
  - ID writes dest 8, then the next instruction reads rs=8 → that instruction shows Ctrl_FwdA=1 in EX.
  - With one unrelated instruction between them → Ctrl_FwdA=2.
  - With both MEM and WB writing reg 8 → Ctrl_FwdA=1.
REQ-036 The bench SHALL cover register zero: a producer with dest 0 and reg_write=1, consumer rs=0 → Ctrl_FwdA=0 and no stall.
REQ-037 The bench SHALL cover load-use: a load to reg 9, immediately followed by rt=9 with uses_rt=1 → for exactly 1 cycle Ctrl_Mux_Select_Stall=0, pc_write=0, ifid_write=0; the consumer then shows Ctrl_FwdB=2 in EX; stall_count=1.
REQ-038 The bench SHALL cover jr after a load:
  - A load to reg 31, immediately followed by jr with rs=31 → 2 stall cycles.
  - ifid_flush=1 only on the third cycle.
  - stall_count=2.
REQ-039 The bench SHALL cover branch flush: id_branch_taken=1 with no hazard → ifid_flush=1 for 1 cycle and pc_write=1.
REQ-040 The bench SHALL cover saturation and reset:
  - Hold the load-use condition by forcing records across 65540 stalls → stall_count=16'hFFFF.
  - Then pulse rst_n=0 mid-stall → stall_count=0, all records clear, pc_write=1 immediately.
